// File: rtl/mlp_ctrl.sv
// mlp_ctrl: sequencing and configuration controller for the 2-2-3-1 MLP.
// It holds the nine weights, accepts an input pair, and holds the MLP
// inputs steady for SETTLE_CYCLES edges. It then registers m_out_i and
// presents the result on a valid/ready output.
// Optional feature: define MLP_CTRL_PERF_EN to build the saturating
// completed-inference counter on inf_count_o. When it is undefined,
// inf_count_o is tied to zero.
//
// state | meaning
// IDLE  | ready for a config write and/or an input accept
// EVAL  | MLP inputs held; settle counter running down to 0
// DONE  | result registered; waiting for out_ready_i
module mlp_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_valid_i,
   output logic        cfg_ready_o,
   input  logic [3:0]  cfg_addr_i,
   input  logic [1:0]  cfg_data_i,
   output logic        cfg_err_o,
   input  logic        in_valid_i,
   output logic        in_ready_o,
   input  logic [1:0]  x0_i,
   input  logic [1:0]  x1_i,
   output logic        out_valid_o,
   input  logic        out_ready_i,
   output logic [1:0]  out_o,
   output logic [1:0]  m_x0_o,
   output logic [1:0]  m_x1_o,
   output logic [1:0]  m_w00_o,
   output logic [1:0]  m_w01_o,
   output logic [1:0]  m_w10_o,
   output logic [1:0]  m_w11_o,
   output logic [1:0]  m_w20_o,
   output logic [1:0]  m_w21_o,
   output logic [1:0]  m_u00_o,
   output logic [1:0]  m_u10_o,
   output logic [1:0]  m_u20_o,
   input  logic [1:0]  m_out_i,
   output logic [15:0] inf_count_o
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EVAL = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  w_q [9];
   logic [1:0]  x0_q, x1_q;
   logic [1:0]  out_q;
   logic        cfg_err_q;
   logic        idle;
   logic        accept;
   logic        cfg_wr;
   logic        capture;

   assign idle   = (state_q == IDLE);
   assign accept = idle && in_valid_i;
   // Writes are only possible in IDLE, so the weights are frozen during EVAL and DONE.
   assign cfg_wr = idle && cfg_valid_i;

   // Next-state logic and settle-counter control.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      capture = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid_i) begin
               state_d = EVAL;
               cnt_d   = 4'(SETTLE_CYCLES - 1);
            end
         end
         EVAL: begin
            if (cnt_q == 4'd0) begin
               capture = 1'b1;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         DONE: begin
            if (out_ready_i) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State register and settle counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Weight register file and registered error pulse for out-of-range addresses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 9; i++) w_q[i] <= 2'd0;
         cfg_err_q <= 1'b0;
      end else begin
         cfg_err_q <= cfg_wr && (cfg_addr_i > 4'd8);
         for (int i = 0; i < 9; i++) begin
            if (cfg_wr && (cfg_addr_i == 4'(i))) w_q[i] <= cfg_data_i;
         end
      end
   end

   // Input operands latched on accept; result captured when the settle window ends.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x0_q  <= 2'd0;
         x1_q  <= 2'd0;
         out_q <= 2'd0;
      end else begin
         if (accept) begin
            x0_q <= x0_i;
            x1_q <= x1_i;
         end
         if (capture) out_q <= m_out_i;
      end
   end

`ifdef MLP_CTRL_PERF_EN
   logic [15:0] inf_cnt_q;

   // Saturating count of completed result handshakes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inf_cnt_q <= 16'd0;
      end else if ((state_q == DONE) && out_ready_i && (inf_cnt_q != 16'hFFFF)) begin
         inf_cnt_q <= inf_cnt_q + 16'd1;
      end
   end

   assign inf_count_o = inf_cnt_q;
`else
   assign inf_count_o = 16'd0;
`endif

   assign cfg_ready_o = idle;
   assign in_ready_o  = idle;
   assign out_valid_o = (state_q == DONE);
   assign cfg_err_o   = cfg_err_q;
   assign out_o       = out_q;
   assign m_x0_o      = x0_q;
   assign m_x1_o      = x1_q;
   assign m_w00_o     = w_q[0];
   assign m_w01_o     = w_q[1];
   assign m_w10_o     = w_q[2];
   assign m_w11_o     = w_q[3];
   assign m_w20_o     = w_q[4];
   assign m_w21_o     = w_q[5];
   assign m_u00_o     = w_q[6];
   assign m_u10_o     = w_q[7];
   assign m_u20_o     = w_q[8];

endmodule

// File: tb/tb_mlp_ctrl.sv
// Directed bench for mlp_ctrl. The MLP is replaced by a stub returning
// m_x0 ^ m_x1, or a free-running forced value during the backpressure scenario.
module tb_mlp_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_valid, cfg_ready, cfg_err;
   logic [3:0]  cfg_addr;
   logic [1:0]  cfg_data;
   logic        in_valid, in_ready;
   logic [1:0]  x0, x1;
   logic        out_valid, out_ready;
   logic [1:0]  res;
   logic [1:0]  m_x0, m_x1;
   logic [1:0]  m_w00, m_w01, m_w10, m_w11, m_w20, m_w21, m_u00, m_u10, m_u20;
   logic [1:0]  m_out;
   logic [15:0] inf_count;

   logic        stub_en;
   logic [1:0]  m_force;
   logic [1:0]  mw [9];
   logic [1:0]  exp_w [9];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   assign m_out = stub_en ? (m_x0 ^ m_x1) : m_force;

   assign mw[0] = m_w00;
   assign mw[1] = m_w01;
   assign mw[2] = m_w10;
   assign mw[3] = m_w11;
   assign mw[4] = m_w20;
   assign mw[5] = m_w21;
   assign mw[6] = m_u00;
   assign mw[7] = m_u10;
   assign mw[8] = m_u20;

   mlp_ctrl #(.SETTLE_CYCLES(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_valid_i (cfg_valid),
      .cfg_ready_o (cfg_ready),
      .cfg_addr_i  (cfg_addr),
      .cfg_data_i  (cfg_data),
      .cfg_err_o   (cfg_err),
      .in_valid_i  (in_valid),
      .in_ready_o  (in_ready),
      .x0_i        (x0),
      .x1_i        (x1),
      .out_valid_o (out_valid),
      .out_ready_i (out_ready),
      .out_o       (res),
      .m_x0_o      (m_x0),
      .m_x1_o      (m_x1),
      .m_w00_o     (m_w00),
      .m_w01_o     (m_w01),
      .m_w10_o     (m_w10),
      .m_w11_o     (m_w11),
      .m_w20_o     (m_w20),
      .m_w21_o     (m_w21),
      .m_u00_o     (m_u00),
      .m_u10_o     (m_u10),
      .m_u20_o     (m_u20),
      .m_out_i     (m_out),
      .inf_count_o (inf_count)
   );

   task automatic test_reset();
      rst_n     = 1'b0;
      cfg_valid = 1'($urandom);
      cfg_addr  = 4'($urandom);
      cfg_data  = 2'($urandom);
      in_valid  = 1'($urandom);
      x0        = 2'($urandom);
      x1        = 2'($urandom);
      out_ready = 1'($urandom);
      stub_en   = 1'b0;
      m_force   = 2'($urandom);
      for (int i = 0; i < 9; i++) exp_w[i] = 2'd0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
      total++; if (res !== 2'd0) begin bad++; $display("FAIL reset_out got=%0d want=0", res); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
      total++; if ({m_x0, m_x1} !== 4'd0) begin bad++; $display("FAIL reset_m_x got=%0d/%0d want=0/0", m_x0, m_x1); end
      total++; if (inf_count !== 16'd0) begin bad++; $display("FAIL reset_inf_count got=%0d want=0", inf_count); end
      for (int i = 0; i < 9; i++) begin
         total++; if (mw[i] !== 2'd0) begin bad++; $display("FAIL reset_weight[%0d] got=%0d want=0", i, mw[i]); end
      end
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x0 = 2'd0;
      x1 = 2'd0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_config();
      for (int i = 0; i < 9; i++) begin
         cfg_valid = 1'b1;
         cfg_addr  = 4'(i);
         cfg_data  = 2'(i % 3 + 1);
         @(posedge clk); #1;
         exp_w[i] = 2'(i % 3 + 1);
         total++; if (mw[i] !== exp_w[i]) begin bad++; $display("FAIL cfg_write[%0d] got=%0d want=%0d", i, mw[i], exp_w[i]); end
         total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_good[%0d] got=%b want=0", i, cfg_err); end
      end
      cfg_addr = 4'd12;
      cfg_data = 2'd3;
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_pulse got=%b want=1", cfg_err); end
      for (int i = 0; i < 9; i++) begin
         total++; if (mw[i] !== exp_w[i]) begin bad++; $display("FAIL cfg_bad_addr_weight[%0d] got=%0d want=%0d", i, mw[i], exp_w[i]); end
      end
      @(posedge clk); #1;
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_one_cycle got=%b want=0", cfg_err); end
   endtask

   task automatic test_inference();
      stub_en   = 1'b1;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      x0 = 2'd2;
      x1 = 2'd3;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x0 = 2'd0;
      x1 = 2'd0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL inf_in_ready_e0 got=%b want=0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inf_out_valid_e0 got=%b want=0", out_valid); end
      total++; if ({m_x0, m_x1} !== {2'd2, 2'd3}) begin bad++; $display("FAIL inf_m_x got=%0d/%0d want=2/3", m_x0, m_x1); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL inf_out_valid_e1 got=%b want=0", out_valid); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL inf_out_valid_e2 got=%b want=1", out_valid); end
      total++; if (res !== 2'd1) begin bad++; $display("FAIL inf_out got=%0d want=1", res); end
   endtask

   task automatic test_backpressure();
      stub_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         x0        = 2'(k);
         x1        = 2'(3 - k);
         cfg_valid = 1'(k % 2 == 0);
         cfg_addr  = 4'(k);
         cfg_data  = ~exp_w[k];
         m_force   = 2'(k);
         @(posedge clk); #1;
         total++; if (res !== 2'd1) begin bad++; $display("FAIL bp_out[%0d] got=%0d want=1", k, res); end
         total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid[%0d] got=%b want=1", k, out_valid); end
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%b want=0", k, in_ready); end
         total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL bp_cfg_ready[%0d] got=%b want=0", k, cfg_ready); end
         total++; if ({m_x0, m_x1} !== {2'd2, 2'd3}) begin bad++; $display("FAIL bp_m_x[%0d] got=%0d/%0d want=2/3", k, m_x0, m_x1); end
         for (int i = 0; i < 9; i++) begin
            total++; if (mw[i] !== exp_w[i]) begin bad++; $display("FAIL bp_weight[%0d][%0d] got=%0d want=%0d", k, i, mw[i], exp_w[i]); end
         end
      end
      cfg_valid = 1'b0;
      x0 = 2'd0;
      x1 = 2'd0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_release_out_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release_in_ready got=%b want=1", in_ready); end
      total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL bp_cfg_err got=%b want=0", cfg_err); end
      stub_en = 1'b1;
   endtask

   task automatic test_simultaneous();
      cfg_valid = 1'b1;
      cfg_addr  = 4'd8;
      cfg_data  = 2'd1;
      @(posedge clk); #1;
      exp_w[8] = 2'd1;
      total++; if (m_u20 !== 2'd1) begin bad++; $display("FAIL sim_pre_u20 got=%0d want=1", m_u20); end
      cfg_data = 2'd3;
      in_valid = 1'b1;
      x0 = 2'd1;
      x1 = 2'd1;
      @(posedge clk); #1;
      exp_w[8]  = 2'd3;
      cfg_valid = 1'b0;
      in_valid  = 1'b0;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL sim_in_ready got=%b want=0", in_ready); end
      for (int e = 0; e < 2; e++) begin
         total++; if (m_u20 !== 2'd3) begin bad++; $display("FAIL sim_u20_eval[%0d] got=%0d want=3", e, m_u20); end
         @(posedge clk); #1;
      end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sim_out_valid got=%b want=1", out_valid); end
      total++; if (res !== 2'd0) begin bad++; $display("FAIL sim_out got=%0d want=0", res); end
      total++; if (m_u20 !== 2'd3) begin bad++; $display("FAIL sim_u20_done got=%0d want=3", m_u20); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL sim_release got=%b want=0", out_valid); end
`ifdef MLP_CTRL_PERF_EN
      total++; if (inf_count !== 16'd2) begin bad++; $display("FAIL sim_inf_count got=%0d want=2", inf_count); end
`else
      total++; if (inf_count !== 16'd0) begin bad++; $display("FAIL sim_inf_count got=%0d want=0", inf_count); end
`endif
   endtask

   task automatic test_reset_mid();
      in_valid = 1'b1;
      x0 = 2'd3;
      x1 = 2'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      x0 = 2'd0;
      rst_n = 1'b0;
      #2;
      for (int i = 0; i < 9; i++) exp_w[i] = 2'd0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid got=%b want=0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_in_ready got=%b want=1", in_ready); end
      total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rmid_cfg_ready got=%b want=1", cfg_ready); end
      total++; if ({m_x0, m_x1} !== 4'd0) begin bad++; $display("FAIL rmid_m_x got=%0d/%0d want=0/0", m_x0, m_x1); end
      total++; if (inf_count !== 16'd0) begin bad++; $display("FAIL rmid_inf_count got=%0d want=0", inf_count); end
      for (int i = 0; i < 9; i++) begin
         total++; if (mw[i] !== 2'd0) begin bad++; $display("FAIL rmid_weight[%0d] got=%0d want=0", i, mw[i]); end
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid_after_in_ready got=%b want=1", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_after_out_valid got=%b want=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic want_v;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      x0 = 2'd3;
      x1 = 2'd1;
      for (int e = 1; e <= 12; e++) begin
         @(posedge clk); #1;
         want_v = (e % 4 == 3);
         total++; if (out_valid !== want_v) begin bad++; $display("FAIL b2b_out_valid[e%0d] got=%b want=%b", e, out_valid, want_v); end
         if (want_v) begin
            total++; if (res !== 2'd2) begin bad++; $display("FAIL b2b_out[e%0d] got=%0d want=2", e, res); end
         end
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
`ifdef MLP_CTRL_PERF_EN
      total++; if (inf_count !== 16'd3) begin bad++; $display("FAIL b2b_inf_count got=%0d want=3", inf_count); end
`else
      total++; if (inf_count !== 16'd0) begin bad++; $display("FAIL b2b_inf_count got=%0d want=0", inf_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_config();
      test_inference();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mlp_ctrl.md
# mlp_ctrl

Sequencing and configuration controller for the combinational 2-2-3-1 MLP datapath. Holds the nine 2-bit weights, captures an input pair through a valid/ready handshake, drives the MLP, waits a fixed settle window for the CLA chains to resolve, then registers the result and presents it on a valid/ready output with backpressure. Sits between the system bus and the `mlp` instance; the `mlp` instance is driven only from this block's `m_*` ports.

## Interface
- `SETTLE_CYCLES`, 2: clock edges the MLP inputs are held stable before `m_out` is sampled; legal range 1..15.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `cfg_valid`  in  1  weight-write request.
- `cfg_ready`  out  1  write accepted this cycle; equals `state==IDLE`.
- `cfg_addr`  in  4  weight select: 0 `w00`, 1 `w01`, 2 `w10`, 3 `w11`, 4 `w20`, 5 `w21`, 6 `u00`, 7 `u10`, 8 `u20`.
- `cfg_data`  in  2  weight value.
- `cfg_err`  out  1  one-cycle pulse on an accepted write with `cfg_addr` > 8.
- `in_valid`, `in_ready`  in / out  1  input handshake; `in_ready` = `state==IDLE`.
- `x0`, `x1`  in  2  input operands, sampled on the accept edge.
- `out_valid`, `out_ready`  out / in  1  result handshake.
- `out`  out  2  registered MLP result.
- `m_x0`, `m_x1`, `m_w00`, `m_w01`, `m_w10`, `m_w11`, `m_w20`, `m_w21`, `m_u00`, `m_u10`, `m_u20`  out  2 each  register outputs driving the `mlp` ports.
- `m_out`  in  2  MLP result.
- `inf_count`  out  16  completed-inference count; see Configuration.

## Operation
- Registers: nine weight regs, two input regs (`m_x0`/`m_x1`), a result reg (`out`), a 4-bit settle counter, and a 2-bit state.
- State machine:
  - IDLE: on `in_valid`, latch `x0`/`x1`, load the counter with `SETTLE_CYCLES-1`, and go to EVAL.
  - EVAL: decrement the counter each edge. On the edge where the counter is 0, capture `m_out` into `out`, set `out_valid`, and go to DONE.
  - DONE: hold `out` and `out_valid`. On `out_valid && out_ready`, clear `out_valid` and go to IDLE.
- Config writes:
  - A write occurs only when `cfg_valid && cfg_ready`.
  - Address 0..8 updates the selected weight reg on that edge.
  - Address 9..15 writes nothing and pulses `cfg_err` high for the following cycle.
  - Outside IDLE, `cfg_valid` is ignored and the request stalls until IDLE.
- A simultaneous config write and input accept in IDLE both take effect on the same edge, so that inference uses the new weight.
- `m_x*` and `m_w*` never change during EVAL or DONE.
- `out` is not combinationally forwarded from `m_out`.
- Reset values:
  - State is IDLE.
  - All weights, `m_x*`, `out`, counter and `inf_count` are 0.
  - `out_valid` and `cfg_err` are 0.
  - `in_ready` and `cfg_ready` are 1.
- Reset mid-operation aborts immediately and asynchronously: `out_valid` drops, the result is discarded and weights clear.

## Timing
- The accept edge is E0. `out_valid` rises after edge E(`SETTLE_CYCLES`), and `m_out` is sampled on that same edge.
  - Example: with `SETTLE_CYCLES`=2, `out_valid` is high in the second cycle after E0.
- The result handshake completes on edge Ek. `in_ready` is high in the cycle after Ek, and the next accept is no earlier than Ek+1.
- Minimum period per inference is `SETTLE_CYCLES`+2 cycles with `out_ready` tied high.
- `cfg_err` is a registered one-cycle pulse.
- `cfg_ready`, `in_ready` and `out_valid` do not depend combinationally on any `*_valid`/`*_ready` input.

## Configuration
- `MLP_CTRL_PERF_EN` defined:
  - `inf_count` increments on each result handshake (`out_valid && out_ready`).
  - It saturates at 16'hFFFF.
  - Reset clears it to 0.
- `MLP_CTRL_PERF_EN` undefined: `inf_count` is tied to 0 and no counter flops exist. The port is present either way.

## Test plan
- Reset: assert `rst_n`=0 with random inputs. Required: `out_valid`=0, `out`=0, all `m_w*` and `m_x*` = 0, `in_ready`=1, `cfg_ready`=1, `cfg_err`=0.
- Config: write addresses 0..8 with data 1,2,3,1,2,3,1,2,3. Required: each `m_w*`/`m_u*` port shows its value one edge after its write. A write to address 12 with data 3 leaves all weights unchanged and gives `cfg_err`=1 for exactly one cycle.
- Inference (`SETTLE_CYCLES`=2; `mlp` model or stub returns `m_out` = `m_x0` ^ `m_x1`): accept `x0`=2, `x1`=3. Required: `in_ready`=0 from the next cycle, `out_valid`=1 exactly two edges after accept, `out`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while toggling `x0`/`x1`, `cfg_valid` and `m_out`. Required: `out` stable, `in_ready`=0, `cfg_ready`=0, no weight change. Raising `out_ready` clears `out_valid` on the next edge.
- Simultaneous events: in IDLE, write `u20`=3 on the same edge an input is accepted. Required: `m_u20`=3 throughout EVAL.
- Reset and counter: assert `rst_n`=0 mid-EVAL, then deassert. Required: `out_valid`=0, state IDLE, weights 0. With `MLP_CTRL_PERF_EN`, three completed handshakes give `inf_count`=3.
